// File: rtl/audio_i2s_out_if.sv
// audio_i2s_out_if: sample/control inputs and I2S/strobe outputs of the audio output stage
interface audio_i2s_out_if;
  logic signed [15:0] psg_left, psg_right, pcm_left, pcm_right;
  logic mute, clip_clr, next_sample, clip_flag, i2s_bck, i2s_lrck, i2s_data;
  modport master (output psg_left, psg_right, pcm_left, pcm_right, mute, clip_clr,
                  input next_sample, clip_flag, i2s_bck, i2s_lrck, i2s_data);
  modport slave (input psg_left, psg_right, pcm_left, pcm_right, mute, clip_clr,
                 output next_sample, clip_flag, i2s_bck, i2s_lrck, i2s_data);
endinterface

// File: rtl/audio_i2s_out.sv
// audio_i2s_out: frame timing master, saturating PSG/PCM mixer and 16-bit I2S serialiser.
// PCM mixing and clip detection exist only when AUDIO_PCM_EN is defined.
module audio_i2s_out #(
  parameter int BCK_DIV = 4
) (
  input logic clk,
  input logic rst_n,
  audio_i2s_out_if.slave bus
);
  localparam int SLOT = 2 * BCK_DIV;
  localparam int FRAME_LEN = 64 * SLOT;
  localparam int CW = $clog2(FRAME_LEN);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d, mix_l, mix_r, word;
  logic [5:0] s;
  logic [4:0] t;
  logic boundary, ns_q, bck_q, bck_d, lrck_q, lrck_d, data_q, data_d;
`ifdef AUDIO_PCM_EN
  logic [16:0] sum_l, sum_r;
  logic clip_l, clip_r, clip_q, clip_d;
  always_comb begin
    sum_l = {bus.psg_left[15], bus.psg_left} + {bus.pcm_left[15], bus.pcm_left};
    sum_r = {bus.psg_right[15], bus.psg_right} + {bus.pcm_right[15], bus.pcm_right};
    clip_l = sum_l[16] ^ sum_l[15];
    clip_r = sum_r[16] ^ sum_r[15];
    mix_l = clip_l ? {sum_l[16], {15{~sum_l[16]}}} : sum_l[15:0];
    mix_r = clip_r ? {sum_r[16], {15{~sum_r[16]}}} : sum_r[15:0];
    clip_d = (boundary & (clip_l | clip_r)) | (clip_q & ~bus.clip_clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) clip_q <= 1'b0;
    else clip_q <= clip_d;
  assign bus.clip_flag = clip_q;
`else
  logic unused_pcm;
  assign unused_pcm = ^{bus.pcm_left, bus.pcm_right, bus.clip_clr};
  assign mix_l = bus.psg_left;
  assign mix_r = bus.psg_right;
  assign bus.clip_flag = 1'b0;
`endif
  // Outputs are derived from the next count so they change exactly as the slot/phase does
  always_comb begin
    boundary = cnt_q == CW'(FRAME_LEN - 1);
    cnt_d = boundary ? '0 : cnt_q + 1'b1;
    sh_l_d = boundary ? (bus.mute ? 16'h0 : mix_l) : sh_l_q;
    sh_r_d = boundary ? (bus.mute ? 16'h0 : mix_r) : sh_r_q;
    s = 6'(cnt_d / CW'(SLOT));
    t = s[4:0];
    word = s[5] ? sh_r_q : sh_l_q;
    bck_d = (cnt_d % CW'(SLOT)) >= CW'(BCK_DIV);
    lrck_d = s[5];
    data_d = (t != 5'd0 && t <= 5'd16) ? word[4'(5'd16 - t)] : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      sh_l_q <= '0;
      sh_r_q <= '0;
      ns_q <= 1'b0;
      bck_q <= 1'b0;
      lrck_q <= 1'b0;
      data_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sh_l_q <= sh_l_d;
      sh_r_q <= sh_r_d;
      ns_q <= boundary;
      bck_q <= bck_d;
      lrck_q <= lrck_d;
      data_q <= data_d;
    end
  assign bus.next_sample = ns_q;
  assign bus.i2s_bck = bck_q;
  assign bus.i2s_lrck = lrck_q;
  assign bus.i2s_data = data_q;
endmodule

// File: tb/tb_audio_i2s_out.sv
// tb_audio_i2s_out: directed vector table plus hand sequences for mute, clip clear and mid-frame reset
module tb_audio_i2s_out;
`ifdef AUDIO_PCM_EN
  localparam bit PCM = 1'b1;
`else
  localparam bit PCM = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  audio_i2s_out_if bus();
  audio_i2s_out #(.BCK_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] pl, pr, ml, mr;
    logic mute;
    logic [15:0] xl, xr;
    logic xc;
    logic [15:0] nl, nr;
  } vec_t;
  vec_t vecs[6];
  int checks = 0, errors = 0;
  logic [15:0] gl, gr;
  bit tim, pad, stab;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // Starts on the negedge of a cnt==0 cycle, ends on the negedge of the next frame's cnt==0
  task automatic capture(input bit first, output logic [15:0] l, output logic [15:0] r,
                         output bit tim_ok, output bit pad_ok, output bit stab_ok);
    logic last;
    l = 16'hxxxx;
    r = 16'hxxxx;
    last = 1'b0;
    tim_ok = 1'b1;
    pad_ok = 1'b1;
    stab_ok = 1'b1;
    for (int c = 0; c < 512; c++) begin
      int s, p;
      s = c / 8;
      p = c % 8;
      if (bus.i2s_bck !== (p >= 4) || bus.i2s_lrck !== (s >= 32) ||
          bus.next_sample !== (c == 0 && !first)) tim_ok = 1'b0;
      if (p == 0) last = bus.i2s_data;
      else if (bus.i2s_data !== last) stab_ok = 1'b0;
      if (p == 4) begin
        if (s >= 1 && s <= 16) l[16-s] = bus.i2s_data;
        else if (s >= 33 && s <= 48) r[48-s] = bus.i2s_data;
        else if (bus.i2s_data !== 1'b0) pad_ok = 1'b0;
      end
      @(negedge clk);
    end
  endtask
  task automatic frame_check(input string tag, input bit first, input logic [15:0] el, input logic [15:0] er);
    capture(first, gl, gr, tim, pad, stab);
    check({tag, "_left"}, 32'(gl), 32'(el));
    check({tag, "_right"}, 32'(gr), 32'(er));
    check({tag, "_timing"}, 32'(tim), 32'd1);
    check({tag, "_padding"}, 32'(pad), 32'd1);
    check({tag, "_stable"}, 32'(stab), 32'd1);
  endtask
  task automatic set_in(input logic [15:0] pl, input logic [15:0] pr, input logic [15:0] ml,
                        input logic [15:0] mr, input logic m);
    bus.psg_left = pl;
    bus.psg_right = pr;
    bus.pcm_left = ml;
    bus.pcm_right = mr;
    bus.mute = m;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{16'hA5C3, 16'h5A3C, 16'h0000, 16'h0000, 1'b0, 16'hA5C3, 16'h5A3C, 1'b0, 16'hA5C3, 16'h5A3C};
    vecs[1] = '{16'h7000, 16'h0100, 16'h2000, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7000, 16'h0100};
    vecs[2] = '{16'h8000, 16'h1234, 16'hFFFF, 16'h0000, 1'b0, 16'h8000, 16'h1234, 1'b1, 16'h8000, 16'h1234};
    vecs[3] = '{16'h0100, 16'hFF00, 16'h7FFF, 16'h8000, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 16'h0100, 16'hFF00};
    vecs[4] = '{16'h1000, 16'hF000, 16'h0123, 16'hFEDC, 1'b0, 16'h1123, 16'hEEDC, 1'b0, 16'h1000, 16'hF000};
    vecs[5] = '{16'h7000, 16'h0000, 16'h2000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    set_in(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    bus.clip_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.next_sample, bus.clip_flag, bus.i2s_bck, bus.i2s_lrck, bus.i2s_data}), 32'd0);
    rst_n = 1'b1;
    frame_check("first_frame", 1'b1, 16'h0, 16'h0);
    check("first_next_sample_512", 32'(bus.next_sample), 32'd1);
    frame_check("second_frame", 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      repeat (200) @(negedge clk);
      set_in(vecs[i].pl, vecs[i].pr, vecs[i].ml, vecs[i].mr, vecs[i].mute);
      bus.clip_clr = 1'b1;
      @(negedge clk);
      bus.clip_clr = 1'b0;
      repeat (311) @(negedge clk);
      check($sformatf("v%0d_clip", i), 32'(bus.clip_flag), 32'(PCM & vecs[i].xc));
      frame_check($sformatf("v%0d", i), 1'b0, PCM ? vecs[i].xl : vecs[i].nl, PCM ? vecs[i].xr : vecs[i].nr);
    end
    set_in(16'h7000, 16'h0000, 16'h2000, 16'h0000, 1'b0);
    repeat (100) @(negedge clk);
    bus.clip_clr = 1'b1;
    repeat (412) @(negedge clk);
    check("clip_set_beats_clear", 32'(bus.clip_flag), 32'(PCM));
    bus.clip_clr = 1'b0;
    @(negedge clk);
    check("clip_sticky", 32'(bus.clip_flag), 32'(PCM));
    bus.clip_clr = 1'b1;
    @(negedge clk);
    bus.clip_clr = 1'b0;
    check("clip_cleared", 32'(bus.clip_flag), 32'd0);
    repeat (510) @(negedge clk);
    set_in(16'hA5C3, 16'h5A3C, 16'h0000, 16'h0000, 1'b0);
    repeat (512) @(negedge clk);
    fork
      frame_check("mute_raise_frame", 1'b0, 16'hA5C3, 16'h5A3C);
      begin
        repeat (100) @(negedge clk);
        bus.mute = 1'b1;
        bus.psg_left = 16'hFFFF;
      end
    join
    fork
      frame_check("muted_frame", 1'b0, 16'h0, 16'h0);
      begin
        repeat (100) @(negedge clk);
        bus.mute = 1'b0;
        bus.psg_left = 16'hA5C3;
      end
    join
    frame_check("unmuted_frame", 1'b0, 16'hA5C3, 16'h5A3C);
    repeat (300) @(negedge clk);
    check("pre_reset_outputs", 32'({bus.i2s_bck, bus.i2s_lrck, bus.i2s_data}), 32'b111);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({bus.next_sample, bus.clip_flag, bus.i2s_bck, bus.i2s_lrck, bus.i2s_data}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame_check("post_reset_frame", 1'b1, 16'h0, 16'h0);
    check("post_reset_next_sample_512", 32'(bus.next_sample), 32'd1);
    frame_check("post_reset_second", 1'b0, 16'hA5C3, 16'h5A3C);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
